// File: rtl/fabric_spi_transmitter.sv
// fabric_spi_transmitter: SPI initiator (mode 0, MSB first). It forwards a word stream to the
// fabric SPI receiver of the next FPGA in a daisy chain. Each frame is framed by cs_no, and
// sclk_o is divided down from clk.
// Optional build macro SPI_TX_READBACK_EN adds the miso_i capture path (rdata_o/rvalid_o).
module fabric_spi_transmitter #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned CS_IDLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  sclk_o,
  output logic                  cs_no,
  output logic                  mosi_o
`ifdef SPI_TX_READBACK_EN
  ,
  input  logic                  miso_i,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o
`endif
);

  // One counter serves the setup hold, the sclk half-period and the cs-high gap.
  localparam int unsigned CntMax = (CLK_DIV > CS_IDLE_CYCLES) ? CLK_DIV : CS_IDLE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned BitW   = $clog2(WORD_WIDTH + 1);

  localparam logic [CntW-1:0] DivLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(CS_IDLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [BitW-1:0] BitsFull = BitW'(WORD_WIDTH);
  localparam logic [BitW-1:0] BitsOne  = BitW'(1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StNext, StGap} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bits_q, bits_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic                  last_q, last_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic                  accept;
  logic                  div_wrap;

  assign accept   = valid_i & ready_q;
  assign div_wrap = (cnt_q == DivLast);

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shreg_d = data_i;
          last_d  = last_i;
          mosi_d  = data_i[WORD_WIDTH-1];
          bits_d  = BitsFull;
          cnt_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        // The setup hold ends with the first sclk rise.
        if (div_wrap) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StShift: begin
        if (!div_wrap) begin
          cnt_d = cnt_q + CntOne;
        end else begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            bits_d = bits_q - BitsOne;
            if (bits_q != BitsOne) begin
              shreg_d = {shreg_q[WORD_WIDTH-2:0], 1'b0};
              mosi_d  = shreg_q[WORD_WIDTH-2];
            end
          end else if (bits_q == '0) begin
            // The low half-period after the final fall has elapsed, so the word is complete.
            state_d = last_q ? StGap : StNext;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      StNext: begin
        // Start in the low phase so mosi_o has a full half-period of setup before the rise.
        if (accept) begin
          shreg_d = data_i;
          last_d  = last_i;
          mosi_d  = data_i[WORD_WIDTH-1];
          bits_d  = BitsFull;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle) || (state_d == StNext);
    busy_d  = (state_d != StIdle);
    cs_n_d  = (state_d == StIdle) || (state_d == StGap);
  end

  // State and output registers; an asynchronous reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bits_q  <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign sclk_o  = sclk_q;
  assign cs_no   = cs_n_q;
  assign mosi_o  = mosi_q;

`ifdef SPI_TX_READBACK_EN
  logic [WORD_WIDTH-1:0] rsh_q, rsh_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  fall;
  logic                  word_done;

  // miso_i is sampled at the end of the sclk high phase.
  assign fall      = (state_q == StShift) && div_wrap && sclk_q;
  assign word_done = fall && (bits_q == BitsOne);

  // Readback shift and word-complete strobe.
  always_comb begin
    rsh_d    = rsh_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (fall) begin
      rsh_d = {rsh_q[WORD_WIDTH-2:0], miso_i};
    end
    if (word_done) begin
      rdata_d  = {rsh_q[WORD_WIDTH-2:0], miso_i};
      rvalid_d = 1'b1;
    end
  end

  // Readback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsh_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rsh_q    <= rsh_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
`endif

endmodule
